// File: rtl/rr_packet_arbiter.sv
// Round-robin packet arbiter: N valid/ready sources share one downstream
// channel. A grant is held for a whole packet. The rotate pointer moves only
// at packet boundaries. A beat watchdog force-ends packets that run too long.
module rr_packet_arbiter #(
  parameter int N         = 4,
  parameter int DW        = 32,
  parameter int IDW       = 2,
  parameter int MAX_BEATS = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req_valid,
  input  logic [N-1:0]    req_last,
  input  logic [N*DW-1:0] req_data,
  output logic [N-1:0]    req_ready,
  output logic            out_valid,
  output logic [DW-1:0]   out_data,
  output logic            out_last,
  output logic [IDW-1:0]  out_id,
  input  logic            out_ready,
  output logic [N-1:0]    grant,
  output logic            busy,
  output logic            err_overrun
);

  localparam int PW = $clog2(N);
  localparam int CW = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] last_ptr;   // in BUSY this is also the granted index
  logic [PW-1:0] win_idx;
  logic [PW:0]   cand;
  logic          win_vld;
  logic [CW-1:0] beat_cnt;
  logic          cnt_max, beat_acc, pkt_end;
  logic [N-1:0]  win_onehot;

  assign cnt_max    = (beat_cnt == CW'(MAX_BEATS - 1));
  assign beat_acc   = out_valid & out_ready;
  assign pkt_end    = beat_acc & out_last;
  assign busy       = |grant;
  assign win_onehot = {{(N-1){1'b0}}, 1'b1} << win_idx;

  // Rotating priority scan starting just above last_ptr; feeds registers only.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = 1; k <= N; k++) begin
      cand = (PW+1)'(last_ptr) + (PW+1)'(k);
      if (cand >= (PW+1)'(N)) cand = cand - (PW+1)'(N);
      if (!win_vld && req_valid[cand[PW-1:0]]) begin
        win_vld = 1'b1;
        win_idx = cand[PW-1:0];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state: leave IDLE on any request; drop to IDLE only at a packet end
  // with nobody (not even the current owner) requesting.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_vld) state_nxt = BUSY;
      BUSY:    if (pkt_end && !win_vld) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant, pointer, beat watchdog and overrun pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant       <= '0;
      last_ptr    <= PW'(N - 1);
      beat_cnt    <= '0;
      err_overrun <= 1'b0;
    end else begin
      err_overrun <= 1'b0;
      if (state == IDLE) begin
        if (win_vld) begin
          grant    <= win_onehot;
          last_ptr <= win_idx;
        end
      end else if (beat_acc) begin
        if (out_last) begin
          // Packet boundary: re-arbitrate in the same cycle for zero bubble.
          beat_cnt    <= '0;
          err_overrun <= ~req_last[last_ptr];
          grant       <= win_vld ? win_onehot : '0;
          if (win_vld) last_ptr <= win_idx;
        end else begin
          beat_cnt <= beat_cnt + 1'b1;
        end
      end
    end
  end

  // Datapath mux: combinational from the registered grant index.
  always_comb begin
    req_ready = '0;
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    out_id    = '0;
    if (state == BUSY) begin
      out_valid           = req_valid[last_ptr];
      out_data            = req_data[last_ptr*DW +: DW];
      out_last            = req_last[last_ptr] | cnt_max;
      out_id              = IDW'(last_ptr);
      req_ready[last_ptr] = out_ready;
    end
  end

endmodule

// File: tb/tb_rr_packet_arbiter.sv
// Directed bench for rr_packet_arbiter. Per-requester beat queues drive the
// inputs. A grant-level model predicts every output each cycle. Directed
// literal checks pin the key behaviours.
module tb_rr_packet_arbiter;
  localparam int N = 4, DW = 32, IDW = 2, MAXB = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [N-1:0]    req_valid, req_last, req_ready, grant;
  logic [N*DW-1:0] req_data;
  logic            out_valid, out_last, out_ready, busy, err_overrun;
  logic [DW-1:0]   out_data;
  logic [IDW-1:0]  out_id;

  rr_packet_arbiter #(.N(N), .DW(DW), .IDW(IDW), .MAX_BEATS(MAXB)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_last(req_last),
    .req_data(req_data), .req_ready(req_ready), .out_valid(out_valid),
    .out_data(out_data), .out_last(out_last), .out_id(out_id),
    .out_ready(out_ready), .grant(grant), .busy(busy), .err_overrun(err_overrun));

  always #5 clk = ~clk;

  int nvec = 0, nerr = 0;

  // Source queues: {last, data} per beat.
  logic [DW:0] bq [N][$];

  // Model state: owner index (-1 = nobody), rotate pointer, beats sent, overrun flag.
  int m_g, m_ptr, m_cnt;
  bit m_ovr;

  function automatic int pick(int from);
    for (int k = 1; k <= N; k++)
      if (req_valid[(from + k) % N]) return (from + k) % N;
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int w;
    if (!rst_n) begin
      m_g = -1; m_ptr = N - 1; m_cnt = 0; m_ovr = 0;
    end else begin
      m_ovr = 0;
      if (m_g < 0) begin
        w = pick(m_ptr);
        if (w >= 0) begin m_g = w; m_ptr = w; end
      end else if (req_valid[m_g] && out_ready) begin
        if (req_last[m_g] || m_cnt == MAXB - 1) begin
          m_ovr = !req_last[m_g];
          m_cnt = 0;
          w = pick(m_g);
          m_g = w;
          if (w >= 0) m_ptr = w;
        end else m_cnt++;
      end
    end
  end

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive();
    logic [DW:0] b;
    for (int i = 0; i < N; i++) begin
      if (bq[i].size() > 0) begin
        b = bq[i][0];
        req_valid[i] = 1'b1;
        req_last[i]  = b[DW];
        req_data[i*DW +: DW] = b[DW-1:0];
      end else begin
        req_valid[i] = 1'b0;
        req_last[i]  = 1'b0;
        req_data[i*DW +: DW] = '0;
      end
    end
  endtask

  task automatic push(int i, int n, bit last, int base);
    for (int k = 0; k < n; k++)
      bq[i].push_back({last && (k == n - 1), DW'(base + k)});
  endtask

  // Snapshot of the last sampled cycle, plus grant history.
  logic [N-1:0]   s_grant, s_ready, s_fire, prev_g;
  logic           s_busy, s_valid, s_last, s_err;
  logic [DW-1:0]  s_data;
  logic [IDW-1:0] s_id;
  logic [N-1:0]   glog [$];

  // One clock: compare at negedge, then advance sources after posedge.
  task automatic step();
    logic [N-1:0] e_grant, e_ready;
    logic e_busy, e_valid, e_last;
    logic [DW-1:0] e_data;
    logic [IDW-1:0] e_id;
    @(negedge clk);
    e_grant = '0; e_ready = '0; e_busy = 0; e_valid = 0; e_last = 0;
    e_data = '0; e_id = '0;
    if (m_g >= 0) begin
      e_grant[m_g] = 1'b1;
      e_busy  = 1'b1;
      e_valid = req_valid[m_g];
      e_data  = req_data[m_g*DW +: DW];
      e_last  = req_last[m_g] || (m_cnt == MAXB - 1);
      e_id    = IDW'(m_g);
      e_ready[m_g] = out_ready;
    end
    nvec++;
    if ({grant, busy, out_valid, out_data, out_last, out_id, req_ready, err_overrun} !==
        {e_grant, e_busy, e_valid, e_data, e_last, e_id, e_ready, m_ovr}) begin
      nerr++;
      $display("FAIL cycle_model @%0t: got g=%b b=%b v=%b d=%h l=%b id=%0d rdy=%b err=%b expected g=%b b=%b v=%b d=%h l=%b id=%0d rdy=%b err=%b",
               $time, grant, busy, out_valid, out_data, out_last, out_id, req_ready, err_overrun,
               e_grant, e_busy, e_valid, e_data, e_last, e_id, e_ready, m_ovr);
    end
    s_grant = grant; s_ready = req_ready; s_busy = busy; s_valid = out_valid;
    s_last = out_last; s_err = err_overrun; s_data = out_data; s_id = out_id;
    s_fire = req_valid & req_ready;
    if (grant != 0 && grant != prev_g) glog.push_back(grant);
    prev_g = grant;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (s_fire[i]) void'(bq[i].pop_front());
    drive();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) bq[i].delete();
    out_ready = 1'b1;
    drive();
    step();
    step();
    rst_n = 1'b1;
    glog.delete();
    prev_g = '0;
  endtask

  initial begin
    int b1, errs, bubbles, last_b1;
    req_valid = '0; req_last = '0; req_data = '0; out_ready = 1'b1;
    #2;

    // 1: single 3-beat packet from requester 0
    do_reset();
    chk("t1_rst_grant", s_grant, 0);
    chk("t1_rst_busy", s_busy, 0);
    chk("t1_rst_valid", s_valid, 0);
    chk("t1_rst_ready", s_ready, 0);
    chk("t1_rst_err", s_err, 0);
    push(0, 3, 1, 'h100);
    drive();
    step();
    chk("t1_latency_grant", s_grant, 0);
    step();
    chk("t1_grant", s_grant, 4'b0001);
    chk("t1_b1_data", s_data, 'h100);
    chk("t1_b1_last", s_last, 0);
    step();
    chk("t1_b2_data", s_data, 'h101);
    step();
    chk("t1_b3_last", s_last, 1);
    chk("t1_b3_id", s_id, 0);
    step();
    // requester 0's own valid was visible at the packet end, so it keeps the grant
    chk("t1_after_grant", s_grant, 4'b0001);
    chk("t1_after_valid", s_valid, 0);

    // 2: all four stream 2-beat packets
    do_reset();
    for (int i = 0; i < N; i++)
      for (int p = 0; p < 3; p++) push(i, 2, 1, 'h200 + i*16 + p*2);
    drive();
    bubbles = 0;
    for (int c = 0; c < 40 && glog.size() < 5; c++) begin
      step();
      if (glog.size() > 0 && !s_valid) bubbles++;
    end
    chk("t2_grants_seen", glog.size(), 5);
    if (glog.size() >= 5) begin
      chk("t2_g0", glog[0], 4'b0001);
      chk("t2_g1", glog[1], 4'b0010);
      chk("t2_g2", glog[2], 4'b0100);
      chk("t2_g3", glog[3], 4'b1000);
      chk("t2_g4", glog[4], 4'b0001);
    end
    chk("t2_bubbles", bubbles, 0);

    // 3: requester 2 alone, back-to-back single-beat packets
    do_reset();
    for (int k = 0; k < 4; k++) push(2, 1, 1, 'h300 + k);
    drive();
    step();
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t3_grant", s_grant, 4'b0100);
      chk("t3_valid", s_valid, 1);
      chk("t3_data", s_data, 'h300 + k);
    end
    chk("t3_model_ptr", m_ptr, 2);

    // 4: requester 1 never sends last; requester 2 competes
    do_reset();
    push(1, 20, 0, 'h400);
    push(2, 2, 1, 'h500);
    drive();
    b1 = 0; errs = 0; last_b1 = 0;
    for (int c = 0; c < 30; c++) begin
      step();
      if (s_err) errs++;
      if (last_b1 == 16) chk("t4_err_pulse", s_err, 1);
      last_b1 = 0;
      if (s_fire[1]) begin
        b1++;
        if (b1 == 15) chk("t4_b15_last", s_last, 0);
        if (b1 == 16) begin chk("t4_b16_last", s_last, 1); last_b1 = 16; end
      end
    end
    chk("t4_err_count", errs, 1);
    chk("t4_beats", b1, 20);
    chk("t4_grants_seen", glog.size(), 3);
    if (glog.size() >= 3) begin
      chk("t4_g0", glog[0], 4'b0010);
      chk("t4_g1", glog[1], 4'b0100);
      chk("t4_g2", glog[2], 4'b0010);
    end

    // 5: stall mid-packet with competitors waiting
    do_reset();
    push(3, 4, 1, 'h600);
    drive();
    s_fire = '0;
    for (int c = 0; c < 10 && !s_fire[3]; c++) step();
    chk("t5_first_beat", s_fire[3], 1);
    out_ready = 1'b0;
    push(0, 2, 1, 'h700);
    push(1, 2, 1, 'h710);
    drive();
    for (int c = 0; c < 5; c++) begin
      step();
      chk("t5_stall_grant", s_grant, 4'b1000);
      chk("t5_stall_ready", s_ready, 0);
      chk("t5_stall_data", s_data, 'h601);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) step();
    chk("t5_grants_seen", glog.size(), 3);
    if (glog.size() >= 3) begin
      chk("t5_g1", glog[1], 4'b0001);
      chk("t5_g2", glog[2], 4'b0010);
    end

    // 6: asynchronous reset mid-packet
    do_reset();
    push(1, 4, 1, 'h800);
    drive();
    s_fire = '0;
    for (int c = 0; c < 10 && !s_fire[1]; c++) step();
    chk("t6_first_beat", s_fire[1], 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_grant", grant, 0);
    chk("t6_async_busy", busy, 0);
    chk("t6_async_valid", out_valid, 0);
    for (int i = 0; i < N; i++) bq[i].delete();
    push(0, 1, 1, 'h900);
    push(1, 1, 1, 'h910);
    drive();
    step();
    chk("t6_rst_ready", s_ready, 0);
    rst_n = 1'b1;
    step();
    step();
    chk("t6_first_winner", s_grant, 4'b0001);
    chk("t6_first_data", s_data, 'h900);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
